rr_decode_arbiter: RTL and testbench
====================================

# rr_decode_arbiter

Round-robin arbiter that shares one downstream resource among 8 requesters and drives its 3-to-8 one-hot select path. It outputs the winner both as a 3-bit index and as a registered one-hot grant vector with the same bit mapping as the team's 3-to-8 decoder (index k sets bit k only). Once granted, a requester keeps the grant until it releases it, drops its request, or exceeds a programmable hold limit. The block sits between the requester ports and the select input of the shared datapath.

## Interface
- MAX_HOLD, default 16: maximum cycles a grant may be held before forced preemption; 0 disables the limit (legal range 0..255).
- clk  in  1  rising-edge clock; all state changes on this edge.
- rst_n  in  1  reset, synchronous, active-low.
- en  in  1  arbitration enable; when 0, no new grant is issued, but an existing grant continues.
- req  in  8  request vector; bit k is requester k.
- release  in  1  current owner finishes; sampled only in GRANT.
- grant_valid  out  1  a grant is active.
- grant_idx  out  3  index of the current or most recent owner.
- grant_onehot  out  8  one-hot of grant_idx while grant_valid=1, else 8'h00.
- timeout  out  1  one-cycle pulse when a grant is ended by MAX_HOLD.

## Operation
- All outputs are registered. FSM states: IDLE, GRANT.
- Priority pointer ptr, 3 bits, resets to 0. Search order is ptr, ptr+1, …, ptr+7, with mod-8 wrap-around. The first set req bit wins.
- IDLE behaviour:
  - If en=1 and req!=0: load grant_idx=winner, grant_onehot=1<<winner, grant_valid=1, hold_cnt=0, and go to GRANT.
  - Otherwise: stay in IDLE with grant_valid=0 and grant_onehot=0. grant_idx retains its value.
- GRANT: hold_cnt increments by 1 every cycle. It saturates at 255 and never wraps.
- GRANT exit conditions, evaluated on each edge:
  - release=1 or req[grant_idx]=0: normal end.
  - Otherwise, if MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1: forced end, and timeout=1 next cycle.
- On any GRANT exit:
  - Go to IDLE; grant_valid and grant_onehot clear to 0.
  - ptr becomes grant_idx+1 (mod 8; 7 wraps to 0).
  - grant_idx holds its value.
- If release and the hold limit coincide, release wins and timeout stays 0.
- req changes on non-owner bits during GRANT have no effect.
- en=0 during GRANT does not end the grant.
- After every grant the FSM spends at least one cycle in IDLE (dead cycle). Two grants are never back-to-back.
- Reset is synchronous and may occur mid-grant: the first edge with rst_n=0 forces IDLE, ptr=0, hold_cnt=0, grant_valid=0, grant_onehot=0, grant_idx=0, timeout=0. Nothing is cleared by the rst_n edge itself.
- Invariant: grant_onehot equals either 0 or exactly one bit, and that bit is grant_idx. A bench assertion checks this every cycle.

## Timing
- Grant latency: req sampled at edge N in IDLE → grant_valid=1 in the cycle after edge N (1 cycle).
- Release latency: release=1 at edge M → grant_valid=0 after edge M. The earliest next grant is after edge M+1.
- Maximum grant length: exactly MAX_HOLD cycles of grant_valid=1. timeout is high in the first IDLE cycle after the grant.
- Worst-case wait with all 8 requesting and every owner holding the limit: 7×(MAX_HOLD+1) cycles.
- timeout is asserted only for one cycle.

## Test plan
- Reset and single request:
  - Stimulus: hold rst_n=0 for 2 edges, then req=8'h04.
  - Required response: all outputs 0 during reset; after 1 edge, grant_idx=2, grant_onehot=8'h04. On release, grant_valid=0 next cycle.
- Round-robin rotation and wrap-around:
  - Stimulus: req=8'hFF, release pulsed on each grant.
  - Required response: grant_idx sequence is 0,1,2,…,7,0, with exactly one dead cycle between grants. With req=8'h81 after a grant to 7, the next grant is 0.
- Hold limit:
  - Stimulus: MAX_HOLD=4; requester 5 holds req with no release.
  - Required response: grant_valid high for exactly 4 cycles; timeout=1 for 1 cycle; next grant goes to the next requester above 5.
  - Same stimulus with release on the 4th cycle: timeout stays 0.
- Request drop and enable:
  - Stimulus: owner 3 deasserts req mid-grant; separately, en=0 during an active grant.
  - Required response: grant_valid drops one cycle after the req drop. With en=0, the grant continues and no new grant issues until en=1.
- Reset mid-grant:
  - Stimulus: pulse rst_n=0 for 1 edge while grant_idx=6 is active, with req=8'hFF held.
  - Required response: outputs clear and ptr=0, so the next grant is idx 0, not 7.
- MAX_HOLD=0:
  - Stimulus: hold req for 300 cycles with no release.
  - Required response: grant stays valid, no timeout pulse, no counter-wrap effects.

Source files
------------

// File: rtl/rr_decode_arbiter.sv
// Round-robin arbiter for 8 requesters sharing one resource. The winner is
// presented both as a 3-bit index and as a registered one-hot select vector
// (index k drives bit k). An owner keeps the grant until it releases, drops
// its request, or reaches the programmable hold limit.
module rr_decode_arbiter #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       en_i,
    input  logic [7:0] req_i,
    input  logic       release_i,
    output logic       grant_valid_o,
    output logic [2:0] grant_idx_o,
    output logic [7:0] grant_onehot_o,
    output logic       timeout_o
);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    // A limit of 0 disables forced preemption entirely.
    localparam bit         HoldEn   = (MAX_HOLD != 0);
    localparam logic [7:0] HoldLast = HoldEn ? 8'(MAX_HOLD - 1) : 8'd0;

    state_e     state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic       grant_valid_q, grant_valid_d;
    logic [2:0] grant_idx_q, grant_idx_d;
    logic [7:0] grant_onehot_q, grant_onehot_d;
    logic       timeout_q, timeout_d;

    logic       win_found;
    logic [2:0] win_idx;
    logic [2:0] cand_idx;
    logic       owner_done;
    logic       hold_hit;

    // Scan requesters starting at the priority pointer, wrapping mod 8.
    always_comb begin
        win_found = 1'b0;
        win_idx   = 3'd0;
        cand_idx  = 3'd0;
        for (int i = 0; i < 8; i++) begin
            cand_idx = ptr_q + 3'(i);
            if (!win_found && req_i[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    // Release has priority over the hold limit, so timeout only fires when the
    // owner would otherwise have kept the grant.
    assign owner_done = release_i || !req_i[grant_idx_q];
    assign hold_hit   = HoldEn && (hold_cnt_q == HoldLast);

    // Next-state and registered-output decode for the IDLE/GRANT machine.
    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        hold_cnt_d     = hold_cnt_q;
        grant_valid_d  = grant_valid_q;
        grant_idx_d    = grant_idx_q;
        grant_onehot_d = grant_onehot_q;
        timeout_d      = 1'b0;

        unique case (state_q)
            StIdle: begin
                grant_valid_d  = 1'b0;
                grant_onehot_d = 8'h00;
                if (en_i && win_found) begin
                    state_d        = StGrant;
                    grant_idx_d    = win_idx;
                    grant_onehot_d = 8'h01 << win_idx;
                    grant_valid_d  = 1'b1;
                    hold_cnt_d     = 8'd0;
                end
            end
            StGrant: begin
                hold_cnt_d = (hold_cnt_q == 8'hFF) ? hold_cnt_q : hold_cnt_q + 8'd1;
                if (owner_done || hold_hit) begin
                    state_d        = StIdle;
                    grant_valid_d  = 1'b0;
                    grant_onehot_d = 8'h00;
                    ptr_d          = grant_idx_q + 3'd1;
                    timeout_d      = !owner_done;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q        <= StIdle;
            ptr_q          <= 3'd0;
            hold_cnt_q     <= 8'd0;
            grant_valid_q  <= 1'b0;
            grant_idx_q    <= 3'd0;
            grant_onehot_q <= 8'h00;
            timeout_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            hold_cnt_q     <= hold_cnt_d;
            grant_valid_q  <= grant_valid_d;
            grant_idx_q    <= grant_idx_d;
            grant_onehot_q <= grant_onehot_d;
            timeout_q      <= timeout_d;
        end
    end

    assign grant_valid_o  = grant_valid_q;
    assign grant_idx_o    = grant_idx_q;
    assign grant_onehot_o = grant_onehot_q;
    assign timeout_o      = timeout_q;

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// Bench for rr_decode_arbiter: one instance with MAX_HOLD=4 for arbitration,
// rotation and preemption scenarios, one with MAX_HOLD=0 for unlimited holds.
module tb_rr_decode_arbiter;

    typedef struct packed {
        logic       rst_n;
        logic       en;
        logic [7:0] req;
        logic       rel;
        logic       v;
        logic [2:0] idx;
        logic       to;
    } step_t;

    logic       clk;
    logic       rst_n, en, rel;
    logic [7:0] req;
    logic       gv, to;
    logic [2:0] gi;
    logic [7:0] goh;

    logic       rst0_n, en0, rel0;
    logic [7:0] req0;
    logic       gv0, to0;
    logic [2:0] gi0;
    logic [7:0] goh0;

    logic [12:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;

    logic       gv_p, to_p, gv0_p, to0_p;
    logic [2:0] gi_p, gi0_p;

    rr_decode_arbiter #(.MAX_HOLD(4)) u_dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .en_i           (en),
        .req_i          (req),
        .release_i      (rel),
        .grant_valid_o  (gv),
        .grant_idx_o    (gi),
        .grant_onehot_o (goh),
        .timeout_o      (to)
    );

    rr_decode_arbiter #(.MAX_HOLD(0)) u_dut0 (
        .clk_i          (clk),
        .rst_ni         (rst0_n),
        .en_i           (en0),
        .req_i          (req0),
        .release_i      (rel0),
        .grant_valid_o  (gv0),
        .grant_idx_o    (gi0),
        .grant_onehot_o (goh0),
        .timeout_o      (to0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected packed output {valid, idx, onehot, timeout} from the spec mapping.
    function automatic logic [12:0] pk(input logic v, input logic [2:0] i, input logic t);
        logic [7:0] oh;
        oh = v ? (8'h01 << i) : 8'h00;
        return {v, i, oh, t};
    endfunction

    function automatic step_t st(input logic r, input logic e, input logic [7:0] q,
                                 input logic rl, input logic v, input logic [2:0] i,
                                 input logic t);
        step_t s;
        s.rst_n = r; s.en = e; s.req = q; s.rel = rl; s.v = v; s.idx = i; s.to = t;
        return s;
    endfunction

    // Per-cycle invariants: one-hot matches idx, timeout is a single pulse,
    // and the owner never changes without a dead cycle.
    always @(negedge clk) begin
        if (!$isunknown({gv, gi, goh, to})) begin
            n_vec++;
            if (goh !== (gv ? (8'h01 << gi) : 8'h00) || (to && to_p) ||
                (gv && gv_p && gi != gi_p)) begin
                n_err++;
                $display("FAIL invariant dut4: got v=%b idx=%0d oh=%h to=%b prev_to=%b, want oh=%h",
                         gv, gi, goh, to, to_p, gv ? (8'h01 << gi) : 8'h00);
            end
        end
        if (!$isunknown({gv0, gi0, goh0, to0})) begin
            n_vec++;
            if (goh0 !== (gv0 ? (8'h01 << gi0) : 8'h00) || to0 ||
                (gv0 && gv0_p && gi0 != gi0_p)) begin
                n_err++;
                $display("FAIL invariant dut0: got v=%b idx=%0d oh=%h to=%b, want oh=%h to=0",
                         gv0, gi0, goh0, to0, gv0 ? (8'h01 << gi0) : 8'h00);
            end
        end
        gv_p  <= gv;   gi_p  <= gi;  to_p  <= to;
        gv0_p <= gv0;  gi0_p <= gi0; to0_p <= to0;
    end

    task automatic test_reset();
        step_t s[$];
        logic [12:0] got, want;
        s.push_back(st(0, 1, 8'h00, 0, 0, 0, 0));
        s.push_back(st(0, 1, 8'h00, 0, 0, 0, 0));
        s.push_back(st(1, 1, 8'h04, 0, 1, 2, 0));
        s.push_back(st(1, 1, 8'h04, 0, 1, 2, 0));
        s.push_back(st(1, 1, 8'h04, 1, 0, 2, 0));
        s.push_back(st(1, 1, 8'h00, 0, 0, 2, 0));
        for (int i = 0; i < s.size(); i++) begin
            rst_n = s[i].rst_n; en = s[i].en; req = s[i].req; rel = s[i].rel;
            exp_q.push_back(pk(s[i].v, s[i].idx, s[i].to));
            @(posedge clk); #1;
            got = {gv, gi, goh, to};
            want = exp_q.pop_front();
            n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL reset step %0d: got v=%b idx=%0d oh=%h to=%b, want v=%b idx=%0d oh=%h to=%b",
                         i, got[12], got[11:9], got[8:1], got[0],
                         want[12], want[11:9], want[8:1], want[0]);
            end
        end
    endtask

    task automatic test_rotation();
        step_t s[$];
        logic [12:0] got, want;
        s.push_back(st(0, 1, 8'h00, 0, 0, 0, 0));
        for (int k = 0; k < 9; k++) begin
            s.push_back(st(1, 1, 8'hFF, 0, 1, 3'(k % 8), 0));
            s.push_back(st(1, 1, 8'hFF, 1, 0, 3'(k % 8), 0));
        end
        // Pointer is 1 here: 7 wins, then wrap-around gives 0.
        s.push_back(st(1, 1, 8'h81, 0, 1, 7, 0));
        s.push_back(st(1, 1, 8'h81, 1, 0, 7, 0));
        s.push_back(st(1, 1, 8'h81, 0, 1, 0, 0));
        s.push_back(st(1, 1, 8'h81, 1, 0, 0, 0));
        for (int i = 0; i < s.size(); i++) begin
            rst_n = s[i].rst_n; en = s[i].en; req = s[i].req; rel = s[i].rel;
            exp_q.push_back(pk(s[i].v, s[i].idx, s[i].to));
            @(posedge clk); #1;
            got = {gv, gi, goh, to};
            want = exp_q.pop_front();
            n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL rotation step %0d: got v=%b idx=%0d oh=%h to=%b, want v=%b idx=%0d oh=%h to=%b",
                         i, got[12], got[11:9], got[8:1], got[0],
                         want[12], want[11:9], want[8:1], want[0]);
            end
        end
    endtask

    task automatic test_hold_limit();
        step_t s[$];
        logic [12:0] got, want;
        s.push_back(st(0, 1, 8'h00, 0, 0, 0, 0));
        s.push_back(st(1, 1, 8'h20, 0, 1, 5, 0));
        s.push_back(st(1, 1, 8'hA8, 0, 1, 5, 0));
        s.push_back(st(1, 1, 8'hA8, 0, 1, 5, 0));
        s.push_back(st(1, 1, 8'hA8, 0, 1, 5, 0));
        s.push_back(st(1, 1, 8'hA8, 0, 0, 5, 1));
        s.push_back(st(1, 1, 8'hA8, 0, 1, 7, 0));
        s.push_back(st(1, 1, 8'hA8, 1, 0, 7, 0));
        // Release coincides with the limit: no timeout.
        s.push_back(st(0, 1, 8'h00, 0, 0, 0, 0));
        s.push_back(st(1, 1, 8'h20, 0, 1, 5, 0));
        s.push_back(st(1, 1, 8'h20, 0, 1, 5, 0));
        s.push_back(st(1, 1, 8'h20, 0, 1, 5, 0));
        s.push_back(st(1, 1, 8'h20, 0, 1, 5, 0));
        s.push_back(st(1, 1, 8'h20, 1, 0, 5, 0));
        s.push_back(st(1, 1, 8'h00, 0, 0, 5, 0));
        for (int i = 0; i < s.size(); i++) begin
            rst_n = s[i].rst_n; en = s[i].en; req = s[i].req; rel = s[i].rel;
            exp_q.push_back(pk(s[i].v, s[i].idx, s[i].to));
            @(posedge clk); #1;
            got = {gv, gi, goh, to};
            want = exp_q.pop_front();
            n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL hold_limit step %0d: got v=%b idx=%0d oh=%h to=%b, want v=%b idx=%0d oh=%h to=%b",
                         i, got[12], got[11:9], got[8:1], got[0],
                         want[12], want[11:9], want[8:1], want[0]);
            end
        end
    endtask

    task automatic test_drop_enable();
        step_t s[$];
        logic [12:0] got, want;
        s.push_back(st(0, 1, 8'h00, 0, 0, 0, 0));
        s.push_back(st(1, 1, 8'h08, 0, 1, 3, 0));
        s.push_back(st(1, 1, 8'h08, 0, 1, 3, 0));
        s.push_back(st(1, 1, 8'h00, 0, 0, 3, 0));
        s.push_back(st(1, 1, 8'h00, 0, 0, 3, 0));
        // Pointer is 4; requester 2 is reached by wrap-around.
        s.push_back(st(1, 0, 8'h04, 0, 0, 3, 0));
        s.push_back(st(1, 1, 8'h04, 0, 1, 2, 0));
        s.push_back(st(1, 0, 8'h04, 0, 1, 2, 0));
        s.push_back(st(1, 0, 8'h04, 0, 1, 2, 0));
        s.push_back(st(1, 0, 8'h04, 1, 0, 2, 0));
        s.push_back(st(1, 0, 8'h04, 0, 0, 2, 0));
        s.push_back(st(1, 0, 8'h04, 0, 0, 2, 0));
        s.push_back(st(1, 1, 8'h04, 0, 1, 2, 0));
        s.push_back(st(1, 1, 8'h04, 1, 0, 2, 0));
        for (int i = 0; i < s.size(); i++) begin
            rst_n = s[i].rst_n; en = s[i].en; req = s[i].req; rel = s[i].rel;
            exp_q.push_back(pk(s[i].v, s[i].idx, s[i].to));
            @(posedge clk); #1;
            got = {gv, gi, goh, to};
            want = exp_q.pop_front();
            n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL drop_enable step %0d: got v=%b idx=%0d oh=%h to=%b, want v=%b idx=%0d oh=%h to=%b",
                         i, got[12], got[11:9], got[8:1], got[0],
                         want[12], want[11:9], want[8:1], want[0]);
            end
        end
    endtask

    task automatic test_reset_mid_grant();
        step_t s[$];
        logic [12:0] got, want;
        s.push_back(st(0, 1, 8'h00, 0, 0, 0, 0));
        s.push_back(st(1, 1, 8'h40, 0, 1, 6, 0));
        s.push_back(st(1, 1, 8'hFF, 0, 1, 6, 0));
        s.push_back(st(0, 1, 8'hFF, 0, 0, 0, 0));
        s.push_back(st(1, 1, 8'hFF, 0, 1, 0, 0));
        s.push_back(st(1, 1, 8'hFF, 1, 0, 0, 0));
        s.push_back(st(1, 1, 8'h00, 0, 0, 0, 0));
        for (int i = 0; i < s.size(); i++) begin
            rst_n = s[i].rst_n; en = s[i].en; req = s[i].req; rel = s[i].rel;
            exp_q.push_back(pk(s[i].v, s[i].idx, s[i].to));
            @(posedge clk); #1;
            got = {gv, gi, goh, to};
            want = exp_q.pop_front();
            n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL reset_mid_grant step %0d: got v=%b idx=%0d oh=%h to=%b, want v=%b idx=%0d oh=%h to=%b",
                         i, got[12], got[11:9], got[8:1], got[0],
                         want[12], want[11:9], want[8:1], want[0]);
            end
        end
    endtask

    task automatic test_max_hold_zero();
        step_t s[$];
        logic [12:0] got, want;
        s.push_back(st(0, 1, 8'h00, 0, 0, 0, 0));
        for (int k = 0; k < 300; k++) s.push_back(st(1, 1, 8'h10, 0, 1, 4, 0));
        s.push_back(st(1, 1, 8'h10, 1, 0, 4, 0));
        s.push_back(st(1, 1, 8'h00, 0, 0, 4, 0));
        for (int i = 0; i < s.size(); i++) begin
            rst0_n = s[i].rst_n; en0 = s[i].en; req0 = s[i].req; rel0 = s[i].rel;
            exp_q.push_back(pk(s[i].v, s[i].idx, s[i].to));
            @(posedge clk); #1;
            got = {gv0, gi0, goh0, to0};
            want = exp_q.pop_front();
            n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL max_hold_zero step %0d: got v=%b idx=%0d oh=%h to=%b, want v=%b idx=%0d oh=%h to=%b",
                         i, got[12], got[11:9], got[8:1], got[0],
                         want[12], want[11:9], want[8:1], want[0]);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run still active at 200000, want completion earlier");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; en = 1'b0; req = 8'h00; rel = 1'b0;
        rst0_n = 1'b0; en0 = 1'b0; req0 = 8'h00; rel0 = 1'b0;
        gv_p = 1'b0; gi_p = 3'd0; to_p = 1'b0;
        gv0_p = 1'b0; gi0_p = 3'd0; to0_p = 1'b0;
        @(negedge clk);
        test_reset();
        test_rotation();
        test_hold_limit();
        test_drop_enable();
        test_reset_mid_grant();
        test_max_hold_zero();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
